parser_arb: RTL and testbench
=============================

PARSER_ARB -- requirements
Module: parser_arb

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 64, the stall limit in cycles (used only under REQ-030).
REQ-003 The block SHALL have port clk, input, 1, the clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port src_valid, input, N_SRC, the per-source byte-valid.
REQ-006 The block SHALL have port src_data, input, N_SRC x 8, the per-source byte.
REQ-007 The block SHALL have port src_last, input, N_SRC, the per-source last byte of frame, qualified by src_valid.
REQ-008 The block SHALL have port src_ready, output, N_SRC, the per-source accept.
REQ-009 The block SHALL have port out_data, output, 8, the byte to the frame parser data input.
REQ-010 The block SHALL have port out_valid, output, 1, the byte strobe to the frame parser data_valid.
REQ-011 The block SHALL have port grant_id, output, clog2(N_SRC), the current or most recent granted source.
REQ-012 The block SHALL have port busy, output, 1, high while in state XFER.
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse when a grant ends.
REQ-014 The block SHALL have port timeout_err, output, 1, a one-cycle pulse when a grant is aborted by stall.

Function
REQ-015 The FSM SHALL have states IDLE, XFER and GAP.
REQ-016 In IDLE with any src_valid high, the block SHALL select a winner by round-robin, searching from last_grant+1 upward with wrap, and SHALL enter XFER next cycle with grant_id = winner and last_grant = winner.
REQ-017 In IDLE with no src_valid, the block SHALL remain in IDLE, and grant_id SHALL hold its value.
REQ-018 src_ready[i] SHALL be combinational: 1 only when state == XFER and grant_id == i; all other bits SHALL be 0.
REQ-019 A transfer SHALL occur when src_valid[g] and src_ready[g] are both high.
REQ-020 On a transfer, out_data SHALL equal src_data[g] and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-021 On cycles without a transfer, out_valid SHALL be 0 and out_data SHALL hold its value.
REQ-022 A transfer with src_last[g] = 1 SHALL move the FSM to GAP; that byte SHALL still be forwarded.
REQ-023 GAP SHALL last exactly 1 cycle, SHALL drive frame_done = 1, and SHALL return to IDLE; no src_ready SHALL be asserted in GAP or IDLE.
REQ-024 A minimum frame-to-frame spacing SHALL apply: last byte accepted at cycle t means the next grant is decided at t+2 and the first byte is accepted at t+3 at earliest.
REQ-025 Non-granted sources SHALL be ignored, whatever their valid/last values.
REQ-026 Deasserting src_valid[g] mid-frame SHALL NOT end the grant; the grant SHALL end only per REQ-022 or REQ-030.
REQ-027 busy SHALL equal (state == XFER).

Reset
REQ-028 With rst_n low at a clock edge, the block SHALL enter IDLE with last_grant = N_SRC-1 (source 0 wins first), grant_id = 0, and out_data, out_valid, frame_done, timeout_err and the stall counter all 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; src_ready SHALL be 0 in the following cycle.

Configuration
REQ-030 With macro PARSER_ARB_TIMEOUT_EN defined:
- A stall counter SHALL count consecutive XFER cycles without a transfer and SHALL clear on each transfer and on entering XFER.
- When the count reaches TIMEOUT_CYC, the FSM SHALL move to GAP and assert timeout_err and frame_done together for 1 cycle.
- No byte SHALL be forwarded that cycle.
REQ-031 With PARSER_ARB_TIMEOUT_EN undefined:
- No counter SHALL exist, and timeout_err SHALL be tied 0.
- A stalled grant SHALL persist until src_last or reset.

Verification
REQ-032 Reset, then src_valid = 4'b0100 with a 21-byte frame (last on byte 21) -> grant_id = 2; out_data reproduces all 21 bytes in order, each 1 cycle after acceptance; frame_done pulses once; busy low thereafter.
REQ-033 All four sources continuously valid with 3-byte frames -> grant order 0, 1, 2, 3, 0; out_valid bursts of 3 separated by exactly 2 idle cycles.
REQ-034 Source 1 granted, drops src_valid for 5 cycles mid-frame while source 3 is valid -> no source-3 bytes appear; the frame resumes and completes from source 1.
REQ-035 With PARSER_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, the granted source stalls -> timeout_err and frame_done high on the same cycle, 8 cycles after the last transfer; next grant to the following source. Without the macro, the same stimulus -> busy stays high and timeout_err stays 0.
REQ-036 rst_n pulsed low on the 4th byte of a frame from source 3 -> out_valid 0, no frame_done; the next grant goes to source 0 even if source 3 is still valid.

Source files
------------

// File: rtl/parser_arb.sv
// Round-robin arbiter that merges N_SRC byte streams, one whole frame per grant, into one parser input.
// Byte out 1 cycle after accept; only the granted source sees ready; optional stall abort under PARSER_ARB_TIMEOUT_EN.
module parser_arb #(
  parameter int N_SRC       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0][7:0]    src_data,
  input  logic [N_SRC-1:0]         src_last,
  output logic [N_SRC-1:0]         src_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout_err
);
  localparam int GW = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        r_state;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] r_grant;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_frame_done;

  logic          w_found;
  logic [GW-1:0] w_winner;
  logic [GW-1:0] w_idx;
  logic          w_xfer;
  logic          w_last;
  logic          w_timeout;

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % N_SRC);
      if (!w_found && src_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (r_state == XFER) src_ready[r_grant] = 1'b1;
  end

  assign w_xfer = (r_state == XFER) && src_valid[r_grant];
  assign w_last = src_last[r_grant];

`ifdef PARSER_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  logic [SW-1:0] r_stall;
  logic          r_timeout_err;

  // Fires on the stalled cycle that brings the count up to TIMEOUT_CYC.
  assign w_timeout = (r_state == XFER) && !w_xfer && (r_stall == SW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if ((r_state != XFER) || w_xfer || w_timeout) r_stall <= '0;
      else                                          r_stall <= r_stall + SW'(1);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = ^TIMEOUT_CYC;
  assign w_timeout            = 1'b0;
  assign timeout_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GW'(N_SRC - 1);
      r_grant      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_xfer;
      r_frame_done <= 1'b0;
      if (w_xfer) r_out_data <= src_data[r_grant];
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= XFER;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        XFER: begin
          // A dropped valid never ends the grant; only last or a stall abort does.
          if ((w_xfer && w_last) || w_timeout) begin
            r_state      <= GAP;
            r_frame_done <= 1'b1;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign grant_id   = r_grant;
  assign busy       = (r_state == XFER);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_parser_arb.sv
// Directed bench for parser_arb: source models feed frames, expected bytes are queued up front and popped on out_valid.
module tb_parser_arb;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      src_valid;
  logic [3:0][7:0] src_data;
  logic [3:0]      src_last;
  logic [3:0]      src_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic [1:0]      grant_id;
  logic            busy;
  logic            frame_done;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int to_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_out = 8'h00;
  int seq[4], cnt[4], rem[4], flen[4], exp_seq[4];
  bit en[4];
  int oh[64];

  always #5 clk = ~clk;

  parser_arb #(.N_SRC(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .out_data(out_data), .out_valid(out_valid), .grant_id(grant_id),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  // Scoreboard side: every emitted byte must match the next queued expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (out_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_byte observed=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        assert (out_data === e) else begin
          bad++;
          $error("FAIL out_byte observed=%0h expected=%0h", out_data, e);
        end
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = en[i] && (rem[i] > 0);
      src_data[i]  = {2'(i), 6'(seq[i])};
      src_last[i]  = (cnt[i] == flen[i] - 1);
    end
  endtask

  task automatic load(input int s, input int nfr, input int len);
    rem[s] = nfr; flen[s] = len; cnt[s] = 0; en[s] = 1'b1;
  endtask

  task automatic exp_frame(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({2'(s), 6'(exp_seq[s])});
      exp_seq[s]++;
    end
  endtask

  // One clock: note the handshake, cross the edge, check 1-cycle forwarding, advance the source models.
  task automatic step();
    logic [3:0] hs;
    logic [7:0] acc;
    logic       rst_at_edge;
    rst_at_edge = rst_n;
    hs  = rst_n ? (src_valid & src_ready) : 4'b0000;
    acc = prev_out;
    for (int i = 0; i < 4; i++) if (hs[i]) acc = src_data[i];
    @(posedge clk);
    #1;
    prev_out = rst_at_edge ? acc : 8'h00;
    if (hs != 4'b0000) chk("ready_onehot", 32'($countones(hs)), 32'd1);
    chk("out_valid_lat", out_valid, 32'(hs != 4'b0000));
    chk("out_data_lat", out_data, prev_out);
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (cnt[i] == flen[i] - 1) begin
          cnt[i] = 0;
          rem[i]--;
        end else begin
          cnt[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; cnt[i] = 0; rem[i] = 0; flen[i] = 1; exp_seq[i] = 0; en[i] = 1'b0;
    end
    exp_q.delete();
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int fd0, to0, f, mism;
    bit found;

    // Reset state
    do_reset();
    chk("rst_grant", grant_id, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", src_ready, 0);

    // Single 21-byte frame from source 2
    load(2, 1, 21); exp_frame(2, 21); drive(); fd0 = fd_cnt;
    step();
    chk("t32_grant", grant_id, 2);
    chk("t32_busy", busy, 1);
    chk("t32_ready", src_ready, 4'b0100);
    repeat (30) step();
    chk("t32_drain", exp_q.size(), 0);
    chk("t32_fd", fd_cnt - fd0, 1);
    chk("t32_busy_end", busy, 0);
    chk("t32_grant_hold", grant_id, 2);

    // All sources valid, 3-byte frames: round-robin order and 2-cycle spacing
    do_reset();
    for (int s = 0; s < 4; s++) load(s, 2, 3);
    for (int r = 0; r < 2; r++) for (int s = 0; s < 4; s++) exp_frame(s, 3);
    drive(); fd0 = fd_cnt;
    for (int k = 0; k < 50; k++) begin
      step();
      oh[k] = int'(out_valid);
    end
    found = 1'b0; f = 0;
    for (int k = 0; k < 50; k++) if (!found && oh[k] == 1) begin found = 1'b1; f = k; end
    chk("t33_first_out", found, 1);
    mism = 0;
    for (int k = 0; k < 38; k++) if (f + k < 50 && oh[f + k] != int'((k % 5) < 3)) mism++;
    chk("t33_spacing", mism, 0);
    chk("t33_drain", exp_q.size(), 0);
    chk("t33_fd", fd_cnt - fd0, 8);

    // Source 1 pauses mid-frame while source 3 waits
    do_reset();
    load(1, 1, 8); load(3, 1, 3); exp_frame(1, 8); exp_frame(3, 3); drive(); fd0 = fd_cnt;
    for (int k = 0; k < 20 && cnt[1] < 3; k++) step();
    chk("t34_progress", cnt[1], 3);
    chk("t34_grant", grant_id, 1);
    en[1] = 1'b0; drive();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t34_hold_ready", src_ready, 4'b0010);
      chk("t34_hold_busy", busy, 1);
    end
    en[1] = 1'b1; drive();
    repeat (25) step();
    chk("t34_drain", exp_q.size(), 0);
    chk("t34_fd", fd_cnt - fd0, 2);

    // Granted source stalls indefinitely
    do_reset();
    load(0, 1, 10); load(1, 1, 2);
`ifdef PARSER_ARB_TIMEOUT_EN
    exp_frame(0, 4);
`else
    exp_frame(0, 10);
`endif
    exp_frame(1, 2); drive(); fd0 = fd_cnt; to0 = to_cnt;
    for (int k = 0; k < 12 && cnt[0] < 4; k++) step();
    chk("t35_progress", cnt[0], 4);
    en[0] = 1'b0; drive();
`ifdef PARSER_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t35_timeout_err", timeout_err, 32'(k == 8));
      chk("t35_frame_done", frame_done, 32'(k == 8));
      chk("t35_busy", busy, 32'(k < 8));
    end
    step();
    step();
    chk("t35_next_grant", grant_id, 1);
    chk("t35_next_busy", busy, 1);
    repeat (10) step();
    chk("t35_drain", exp_q.size(), 0);
    chk("t35_fd", fd_cnt - fd0, 2);
    chk("t35_to_cnt", to_cnt - to0, 1);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t35_stall_busy", busy, 1);
      chk("t35_stall_to", timeout_err, 0);
    end
    en[0] = 1'b1; drive();
    repeat (25) step();
    chk("t35_drain", exp_q.size(), 0);
    chk("t35_fd", fd_cnt - fd0, 2);
    chk("t35_to_cnt", to_cnt - to0, 0);
`endif

    // Reset during the 4th byte of a source-3 frame
    do_reset();
    load(3, 1, 10); exp_frame(3, 3); drive(); fd0 = fd_cnt;
    for (int k = 0; k < 12 && cnt[3] < 3; k++) step();
    chk("t36_progress", cnt[3], 3);
    chk("t36_grant", grant_id, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t36_fd_after_rst", frame_done, 0);
    chk("t36_ready_after_rst", src_ready, 0);
    chk("t36_busy_after_rst", busy, 0);
    load(0, 1, 2); exp_frame(0, 2); exp_frame(3, 7); drive();
    step();
    chk("t36_next_grant", grant_id, 0);
    chk("t36_next_busy", busy, 1);
    repeat (20) step();
    chk("t36_drain", exp_q.size(), 0);
    chk("t36_fd", fd_cnt - fd0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
